// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit.
//   Iterative radix-2 multiply (or single-cycle when FAST_MUL != 0) and
//   restoring radix-2 divide, both on operand magnitudes with sign fix-up
//   on the final edge. MTHI/MTLO write HI or LO directly.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   start_i       request, op_i/srca_i/srcb_i sampled on the accepting edge
//   op_i          000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   srca_i/srcb_i operands
//   flush_i       cancel in-flight operation (also drops a same-cycle start)
//   busy_o        operation in progress
//   done_o        one-cycle pulse after a HI/LO update
//   hi_o/lo_o     HI and LO registers
module muldiv_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / dividend-quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand / divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;   // negate product or quotient
    logic               neg_hi_q, neg_hi_d;   // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand signs and magnitudes for the signed ops
    logic               sgn_op, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

    assign sgn_op    = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign sa        = sgn_op & srca_i[WIDTH-1];
    assign sb        = sgn_op & srcb_i[WIDTH-1];
    assign mag_a     = sa ? (-srca_i) : srca_i;
    assign mag_b     = sb ? (-srcb_i) : srcb_i;
    assign ext_a     = {{WIDTH{sa}}, srca_i};
    assign ext_b     = {{WIDTH{sb}}, srcb_i};
    assign fast_prod = ext_a * ext_b;

    // One shift-add multiply step
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign prod     = {mul_hi, mul_lo};
    assign prod_fix = neg_lo_q ? (-prod) : prod;

    // One restoring divide step; a zero divisor yields all-ones quotient
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_hi, div_lo, div_q_fix, div_r_fix;

    assign div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_sh >= {1'b0, opnd_q};
    assign div_diff  = div_sh[WIDTH-1:0] - opnd_q;
    assign div_hi    = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_lo    = {acc_lo_q[WIDTH-2:0], div_ge};
    assign div_q_fix = neg_lo_q ? (-div_lo) : div_lo;
    assign div_r_fix = neg_hi_q ? (-div_hi) : div_hi;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            if (FAST_MUL != 0) begin
                                hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                                lo_d   = fast_prod[WIDTH-1:0];
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_RUN;
                                cnt_d    = CNT_W'(WIDTH);
                                acc_hi_d = '0;
                                acc_lo_d = mag_b;
                                opnd_d   = mag_a;
                                is_div_d = 1'b0;
                                neg_lo_d = sa ^ sb;
                                neg_hi_d = 1'b0;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = ST_RUN;
                            cnt_d    = CNT_W'(WIDTH);
                            acc_hi_d = '0;
                            acc_lo_d = mag_a;
                            opnd_d   = mag_b;
                            is_div_d = 1'b1;
                            // keep the all-ones quotient for a zero divisor
                            neg_lo_d = (sa ^ sb) && (srcb_i != '0);
                            neg_hi_d = sa;
                        end
                        OP_MTHI: begin
                            hi_d   = srca_i;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = srca_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_hi_d = is_div_q ? div_hi : mul_hi;
                    acc_lo_d = is_div_q ? div_lo : mul_lo;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (is_div_q) begin
                            hi_d = div_r_fix;
                            lo_d = div_q_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                    end
                end
            end
        endcase
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and HI/LO width (legal 8..64, even).
REQ-002 SHALL have parameter FAST_MUL, default 0: 0 = iterative multiply, 1 = single-cycle multiply.
REQ-003 SHALL provide clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide start_i  input  1  request; op and operands sampled on the same edge.
REQ-006 SHALL provide op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-007 SHALL provide srca_i  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-008 SHALL provide srcb_i  input  WIDTH  multiplier / divisor.
REQ-009 SHALL provide flush_i  input  1  cancel the in-flight operation.
REQ-010 SHALL provide busy_o  output  1  operation in progress; pipeline stalls on it.
REQ-011 SHALL provide done_o  output  1  one-cycle pulse on HI/LO update.
REQ-012 SHALL provide hi_o  output  WIDTH  HI register (product high half / remainder).
REQ-013 SHALL provide lo_o  output  WIDTH  LO register (product low half / quotient).

Function
REQ-014 SHALL implement FSM states IDLE and RUN; busy_o = (state == RUN).
REQ-015 SHALL accept start_i only in IDLE with flush_i low; start_i in RUN ignored, operands not resampled.
REQ-016 SHALL, for DIV/DIVU (and MULT/MULTU when FAST_MUL=0), enter RUN at accept edge E0, load iteration counter with WIDTH, perform one radix-2 step per cycle.
REQ-017 SHALL hold busy_o high for exactly WIDTH cycles after E0; on edge E0+WIDTH write HI/LO, return to IDLE, assert done_o for the following single cycle.
REQ-018 SHALL, for MULT/MULTU with FAST_MUL=1 and for MTHI/MTLO, update at E0 with no busy cycle and pulse done_o the cycle after E0.
REQ-019 SHALL have MTHI write only HI, MTLO write only LO; undefined op_i changes nothing and pulses nothing.
REQ-020 SHALL compute MULT as full 2*WIDTH-bit two's-complement product, MULTU as unsigned; HI = upper WIDTH bits, LO = lower.
REQ-021 SHALL compute DIV on magnitudes then fix signs: quotient negative iff operand signs differ; remainder takes dividend sign (truncating division).
REQ-022 SHALL give DIV of most-negative by -1: LO = 2^(WIDTH-1), HI = 0 (wrap, no flag).
REQ-023 SHALL give divisor zero (DIV or DIVU) after the full WIDTH cycles: LO = all ones, HI = srca_i as sampled.
REQ-024 SHALL keep HI/LO unchanged throughout RUN until the final edge.
REQ-025 SHALL, on flush_i high in RUN (including the final cycle), return to IDLE next edge, leave HI/LO unchanged, suppress done_o.
REQ-026 SHALL let flush_i win over start_i in the same IDLE cycle (request dropped).
REQ-027 SHALL accept a new start_i in the cycle done_o is high (back-to-back operations).

Reset
REQ-028 SHALL, while rst is low and regardless of clk, force state IDLE, counter 0, hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0.
REQ-029 SHALL abort any in-flight operation on reset with no later HI/LO update or done_o pulse.

Verification (WIDTH=32)
REQ-030 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF, FAST_MUL=0 -> busy_o high 32 cycles, then hi_o=0xFFFFFFFE, lo_o=0x00000001, one done_o pulse.
REQ-031 SHALL cover MULT 0x80000000 x 0x80000000, FAST_MUL=1 -> no busy, next cycle hi_o=0x40000000, lo_o=0x00000000.
REQ-032 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 0x1234 / 0 -> lo_o=0xFFFFFFFF, hi_o=0x1234.
REQ-033 SHALL cover DIVU with flush_i pulsed in busy cycle 10 -> busy_o low next cycle, hi_o/lo_o keep prior values, no done_o.
REQ-034 SHALL cover start_i reasserted mid-RUN with new operands -> ignored, first result intact; then MTHI 0x5A5A -> hi_o=0x5A5A, lo_o unchanged.
REQ-035 SHALL cover rst low asynchronously mid-DIV -> outputs zero immediately, no done_o after release.
